// File: rtl/collision_detector_pkg.sv
// Shared game types: obstacle slot layout, slot count and the per-slot hit test.
package collision_detector_pkg;

    localparam int NUM_OBSTACLES   = 10;
    localparam int OBSTACLE_WIDTH  = 64;
    localparam int SPRITE_TALL_BIT = 1;

    typedef struct packed {
        logic        active;
        logic [1:0]  lane;
        logic [10:0] position;     // right-edge x in pixels
        logic [1:0]  sprite_type;  // types 0/1 can be jumped, 2/3 are tall
    } obstacle;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REPORT
    } scan_state_t;

    // A slot hits when it is live, in the player's lane, overlaps the player
    // horizontally, and is not a low sprite being cleared by a jump.
    function automatic logic slot_hits(
        input obstacle     slot,
        input logic [1:0]  lane,
        input logic        airborne,
        input logic [11:0] left_x,
        input logic [11:0] right_x
    );
        logic [11:0] pos;
        pos = {1'b0, slot.position};
        return slot.active
            && (slot.lane == lane)
            && (pos > left_x)
            && (pos < right_x)
            && !(!slot.sprite_type[SPRITE_TALL_BIT] && airborne);
    endfunction

endpackage

// File: rtl/collision_detector_if.sv
// Game-side bus of the collision detector: frame strobe, slot array, player
// controls in; jump, hit and scan status out.
interface collision_detector_if;
    import collision_detector_pkg::*;

    logic                               frame_trigger;
    obstacle [NUM_OBSTACLES-1:0]        obstacles_in;
    logic [1:0]                         player_lane;
    logic                               player_jump;
    logic                               airborne;
    logic                               collision;
    logic [3:0]                         hit_index;
    logic                               game_over;
    logic                               scan_busy;
    logic                               frame_overrun;

    modport master (
        output frame_trigger, obstacles_in, player_lane, player_jump,
        input  airborne, collision, hit_index, game_over, scan_busy, frame_overrun
    );

    modport slave (
        input  frame_trigger, obstacles_in, player_lane, player_jump,
        output airborne, collision, hit_index, game_over, scan_busy, frame_overrun
    );

endinterface

// File: rtl/collision_detector_jump_tracker.sv
// Jump arc tracker: a rising edge of the jump request starts a countdown of
// JUMP_FRAMES frames during which the player is airborne. Shared with the
// renderer for sprite height.
module jump_tracker #(
    parameter int JUMP_FRAMES = 30
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic frame_trigger,
    input  logic player_jump,
    output logic airborne
);

    logic [5:0] jump_count;
    logic       jump_prev;
    logic       jump_rise;

    assign jump_rise = player_jump & ~jump_prev;

    // Edge detect and frame countdown; a new jump beats a same-cycle decrement.
    always_ff @(posedge clk_in) begin
        // NOTE: reset is synchronous, so it is just the highest-priority branch
        // of the clocked block and never appears in the sensitivity list.
        if (rst_in) begin
            jump_count <= '0;
            jump_prev  <= 1'b0;
            airborne   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based
            // on pre-edge values regardless of statement order.
            jump_prev <= player_jump;
            if (jump_rise && !airborne) begin
                jump_count <= 6'(JUMP_FRAMES);
                airborne   <= 1'b1;
            end else if (airborne && frame_trigger) begin
                jump_count <= jump_count - 6'd1;
                if (jump_count == 6'd1) begin
                    airborne <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/collision_detector.sv
// Per-frame collision scan: after each frame_trigger, tests one obstacle slot
// per cycle, reports the lowest hitting slot and latches game_over.
module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int PLAYER_X     = 128,
    parameter int PLAYER_WIDTH = 64,
    parameter int JUMP_FRAMES  = 30
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 game_reset,
    collision_detector_if.slave  bus
);

    localparam logic [11:0] LEFT_X   = 12'(PLAYER_X);
    localparam logic [11:0] RIGHT_X  = 12'(PLAYER_X + PLAYER_WIDTH + OBSTACLE_WIDTH);
    localparam logic [3:0]  LAST_IDX = 4'(NUM_OBSTACLES - 1);

    scan_state_t state;
    logic        sync_rst;
    logic [3:0]  scan_idx;
    logic        scan_airborne;
    logic [1:0]  scan_lane;
    logic        hit_found;
    logic [3:0]  hit_slot;
    logic        slot_hit;

    assign sync_rst = rst_in | game_reset;

    jump_tracker #(
        .JUMP_FRAMES (JUMP_FRAMES)
    ) u_jump_tracker (
        .clk_in        (clk_in),
        .rst_in        (sync_rst),
        .frame_trigger (bus.frame_trigger),
        .player_jump   (bus.player_jump),
        .airborne      (bus.airborne)
    );

    // Hit test for the slot under the scan pointer, read live from the bus.
    always_comb begin
        slot_hit = 1'b0;
        if (state == ST_SCAN) begin
            slot_hit = slot_hits(bus.obstacles_in[scan_idx], scan_lane,
                                 scan_airborne, LEFT_X, RIGHT_X);
        end
    end

    // Scan FSM with registered status outputs; the report is registered on
    // the last scan cycle so it is visible for the whole REPORT cycle.
    always_ff @(posedge clk_in) begin
        if (sync_rst) begin
            state             <= ST_IDLE;
            scan_idx          <= '0;
            scan_airborne     <= 1'b0;
            scan_lane         <= '0;
            hit_found         <= 1'b0;
            hit_slot          <= '0;
            bus.collision     <= 1'b0;
            bus.hit_index     <= '0;
            bus.game_over     <= 1'b0;
            bus.scan_busy     <= 1'b0;
            bus.frame_overrun <= 1'b0;
        end else begin
            bus.collision <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.frame_trigger && !bus.game_over) begin
                        state         <= ST_SCAN;
                        bus.scan_busy <= 1'b1;
                        scan_airborne <= bus.airborne;
                        scan_lane     <= bus.player_lane;
                        scan_idx      <= '0;
                        hit_found     <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (bus.frame_trigger) begin
                        bus.frame_overrun <= 1'b1;
                    end
                    if (slot_hit && !hit_found) begin
                        hit_found <= 1'b1;
                        hit_slot  <= scan_idx;
                    end
                    if (scan_idx == LAST_IDX) begin
                        state         <= ST_REPORT;
                        bus.scan_busy <= 1'b0;
                        if (hit_found || slot_hit) begin
                            bus.collision <= 1'b1;
                            bus.game_over <= 1'b1;
                            bus.hit_index <= hit_found ? hit_slot : scan_idx;
                        end
                    end else begin
                        scan_idx <= scan_idx + 4'd1;
                    end
                end
                ST_REPORT: begin
                    if (bus.frame_trigger) begin
                        bus.frame_overrun <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: directed reset/scan/jump/overrun
// sequences, a boundary vector table, and randomized frames against a
// behavioural model of jump state and slot hits.
module tb_collision_detector;
    import collision_detector_pkg::*;

    localparam int JF = 30;
    localparam int PX = 128;
    localparam int PW = 64;

    logic clk_in = 1'b0;
    logic rst_in;
    logic game_reset;

    collision_detector_if bus();

    collision_detector #(
        .PLAYER_X     (PX),
        .PLAYER_WIDTH (PW),
        .JUMP_FRAMES  (JF)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .game_reset (game_reset),
        .bus        (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Behavioural jump model: frames of air time left.
    int   m_jump_left = 0;
    logic m_jump_prev = 1'b0;

    typedef struct {
        int         slot;
        logic [1:0] lane;
        int         pos;
        logic [1:0] sprite;
        logic       active;
        logic [1:0] plane;
        int         exp_idx;  // -1 means no hit
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: update the model with the inputs being sampled,
    // then look at the DUT 1 ns after the edge.
    task automatic tick();
        if (rst_in || game_reset) begin
            m_jump_left = 0;
            m_jump_prev = 1'b0;
        end else begin
            if (bus.player_jump && !m_jump_prev && m_jump_left == 0)
                m_jump_left = JF;
            else if (bus.frame_trigger && m_jump_left > 0)
                m_jump_left--;
            m_jump_prev = bus.player_jump;
        end
        @(posedge clk_in);
        #1;
        check("airborne", bus.airborne, m_jump_left > 0);
    endtask

    task automatic clear_obstacles();
        for (int i = 0; i < NUM_OBSTACLES; i++) bus.obstacles_in[i] = '0;
    endtask

    function automatic int model_first_hit();
        for (int i = 0; i < NUM_OBSTACLES; i++) begin
            obstacle o;
            int      pos;
            o   = bus.obstacles_in[i];
            pos = int'(o.position);
            if (o.active && o.lane == bus.player_lane && pos > PX
                && pos < PX + PW + OBSTACLE_WIDTH
                && !(o.sprite_type < 2 && m_jump_left > 0))
                return i;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_collision"}, bus.collision, 0);
        check({name, "_hit_index"}, bus.hit_index, 0);
        check({name, "_game_over"}, bus.game_over, 0);
        check({name, "_scan_busy"}, bus.scan_busy, 0);
        check({name, "_overrun"},   bus.frame_overrun, 0);
        check({name, "_airborne"},  bus.airborne, 0);
    endtask

    // One frame: trigger at T, busy T+1..T+10, report at T+11, pulse gone at T+12.
    task automatic run_frame(input int exp_idx, input string name);
        int busy_n;
        int early_coll;
        busy_n = 0;
        early_coll = 0;
        bus.frame_trigger = 1'b1;
        tick();
        bus.frame_trigger = 1'b0;
        repeat (10) begin
            if (bus.scan_busy) busy_n++;
            if (bus.collision) early_coll++;
            tick();
        end
        check({name, "_busy_cycles"}, busy_n, 10);
        check({name, "_early_collision"}, early_coll, 0);
        check({name, "_collision"}, bus.collision, exp_idx >= 0);
        check({name, "_busy_at_report"}, bus.scan_busy, 0);
        check({name, "_game_over"}, bus.game_over, exp_idx >= 0);
        if (exp_idx >= 0) check({name, "_hit_index"}, bus.hit_index, exp_idx);
        tick();
        check({name, "_pulse_end"}, bus.collision, 0);
    endtask

    // Trigger while game_over is set: nothing may scan or pulse.
    task automatic run_blocked_frame(input string name);
        int busy_n;
        int coll_n;
        busy_n = 0;
        coll_n = 0;
        bus.frame_trigger = 1'b1;
        tick();
        bus.frame_trigger = 1'b0;
        repeat (12) begin
            if (bus.scan_busy) busy_n++;
            if (bus.collision) coll_n++;
            tick();
        end
        check({name, "_busy"}, busy_n, 0);
        check({name, "_collision"}, coll_n, 0);
        check({name, "_game_over"}, bus.game_over, 1);
    endtask

    task automatic pulse_game_reset(input string name);
        game_reset = 1'b1;
        tick();
        game_reset = 1'b0;
        check_all_zero(name);
    endtask

    initial begin
        vecs[0] = '{4, 2'd1, 128, 2'd2, 1'b1, 2'd1, -1};
        vecs[1] = '{4, 2'd1, 129, 2'd2, 1'b1, 2'd1,  4};
        vecs[2] = '{4, 2'd1, 255, 2'd2, 1'b1, 2'd1,  4};
        vecs[3] = '{4, 2'd1, 256, 2'd2, 1'b1, 2'd1, -1};
        vecs[4] = '{4, 2'd2, 200, 2'd2, 1'b1, 2'd1, -1};
        vecs[5] = '{0, 2'd3, 200, 2'd0, 1'b1, 2'd3,  0};
        vecs[6] = '{9, 2'd0, 200, 2'd1, 1'b1, 2'd0,  9};
        vecs[7] = '{4, 2'd1, 200, 2'd3, 1'b0, 2'd1, -1};

        bus.frame_trigger = 1'b0;
        bus.player_lane   = 2'd0;
        bus.player_jump   = 1'b0;
        clear_obstacles();
        rst_in     = 1'b1;
        game_reset = 1'b0;
        repeat (2) tick();
        rst_in = 1'b0;
        tick();
        check_all_zero("reset");

        // Empty field: three frames, never a collision.
        for (int f = 0; f < 3; f++) begin
            run_frame(-1, "empty");
            repeat (2) tick();
        end

        // Tall obstacle in slot 4 on the player's lane.
        bus.player_lane = 2'd1;
        bus.obstacles_in[4] = '{active: 1'b1, lane: 2'd1, position: 11'd200, sprite_type: 2'd2};
        run_frame(4, "basic");
        run_blocked_frame("basic_blocked");
        pulse_game_reset("basic_greset");

        // Boundary and lane table.
        foreach (vecs[v]) begin
            clear_obstacles();
            bus.player_lane = vecs[v].plane;
            bus.obstacles_in[vecs[v].slot] = '{active: vecs[v].active, lane: vecs[v].lane,
                                              position: 11'(vecs[v].pos),
                                              sprite_type: vecs[v].sprite};
            run_frame(vecs[v].exp_idx, $sformatf("vec%0d", v));
            if (bus.game_over) pulse_game_reset($sformatf("vec%0d_greset", v));
            tick();
        end

        // Jumpable obstacle cleared while airborne, hit once the jump ends.
        clear_obstacles();
        bus.player_lane = 2'd1;
        bus.obstacles_in[4] = '{active: 1'b1, lane: 2'd1, position: 11'd200, sprite_type: 2'd0};
        bus.player_jump = 1'b1;
        tick();
        bus.player_jump = 1'b0;
        check("jump_start_airborne", bus.airborne, 1);
        for (int f = 1; f <= JF; f++) begin
            run_frame(-1, "jump_frame");
            if (f == JF - 1) check("jump_still_airborne", bus.airborne, 1);
            tick();
        end
        check("jump_landed_airborne", bus.airborne, 0);
        run_frame(4, "jump_landed");
        pulse_game_reset("jump_greset");

        // Two hitting slots: lowest index wins, no second pulse until reset.
        clear_obstacles();
        bus.obstacles_in[2] = '{active: 1'b1, lane: 2'd1, position: 11'd200, sprite_type: 2'd3};
        bus.obstacles_in[7] = '{active: 1'b1, lane: 2'd1, position: 11'd150, sprite_type: 2'd2};
        run_frame(2, "two_slots");
        run_blocked_frame("two_blocked_a");
        run_blocked_frame("two_blocked_b");
        check("two_hit_index_held", bus.hit_index, 2);
        pulse_game_reset("two_greset");

        // Overrun: triggers at T and T+5, rst_in at T+6 kills the pending hit.
        clear_obstacles();
        bus.obstacles_in[4] = '{active: 1'b1, lane: 2'd1, position: 11'd200, sprite_type: 2'd2};
        bus.frame_trigger = 1'b1;
        tick();
        bus.frame_trigger = 1'b0;
        repeat (4) tick();
        bus.frame_trigger = 1'b1;
        tick();
        bus.frame_trigger = 1'b0;
        check("overrun_flag", bus.frame_overrun, 1);
        check("overrun_busy", bus.scan_busy, 1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check_all_zero("overrun_rst");
        begin
            int coll_n;
            int busy_n;
            coll_n = 0;
            busy_n = 0;
            repeat (12) begin
                tick();
                if (bus.collision) coll_n++;
                if (bus.scan_busy) busy_n++;
            end
            check("overrun_no_pulse", coll_n, 0);
            check("overrun_no_rescan", busy_n, 0);
        end

        // Randomized frames against the model.
        for (int r = 0; r < 40; r++) begin
            int exp_idx;
            clear_obstacles();
            for (int i = 0; i < NUM_OBSTACLES; i++) begin
                bus.obstacles_in[i] = '{active: ($urandom_range(0, 3) == 0),
                                        lane: 2'($urandom_range(0, 3)),
                                        position: 11'($urandom_range(100, 300)),
                                        sprite_type: 2'($urandom_range(0, 3))};
            end
            bus.player_lane = 2'($urandom_range(0, 3));
            bus.player_jump = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 4)) tick();
            exp_idx = model_first_hit();
            run_frame(exp_idx, $sformatf("rand%0d", r));
            if (exp_idx >= 0) pulse_game_reset($sformatf("rand%0d_greset", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
